// File: rtl/uart_bridge_pkg.sv
// Shared FSM encoding and command bytes for the UART command bridge.
// UART_BRIDGE_CKSUM_EN adds the GET_CKSUM state to the encoding.
package uart_bridge_pkg;

   localparam logic [7:0] CMD_WR = 8'h57;
   localparam logic [7:0] CMD_RD = 8'h52;

   typedef enum logic [2:0] {
      IDLE,
      GET_ADDR,
      GET_DATA,
`ifdef UART_BRIDGE_CKSUM_EN
      GET_CKSUM,
`endif
      BUS_REQ,
      BUS_WAIT,
      SEND_RESP
   } state_t;

   // States in which the bridge may pop the UART RX FIFO
   function automatic logic is_rx_state(state_t s);
      logic r;
      r = (s == IDLE) || (s == GET_ADDR) || (s == GET_DATA);
`ifdef UART_BRIDGE_CKSUM_EN
      r = r || (s == GET_CKSUM);
`endif
      return r;
   endfunction

endpackage

// File: rtl/uart_cmd_bridge_if.sv
// UART FIFO handshake plus register bus seen by the command bridge.
// master = bridge side, slave = UART / register-file side.
interface uart_cmd_bridge_if;
   logic [7:0] rd_out;
   logic       rf_empty;
   logic       tf_full;
   logic       rd_stb;
   logic       wr_stb;
   logic [7:0] wr_in;
   logic [7:0] reg_addr;
   logic [7:0] reg_wdata;
   logic       reg_wr;
   logic       reg_rd;
   logic [7:0] reg_rdata;
   logic       reg_ack;

   modport master (
      input  rd_out, rf_empty, tf_full, reg_rdata, reg_ack,
      output rd_stb, wr_stb, wr_in, reg_addr, reg_wdata, reg_wr, reg_rd
   );

   modport slave (
      output rd_out, rf_empty, tf_full, reg_rdata, reg_ack,
      input  rd_stb, wr_stb, wr_in, reg_addr, reg_wdata, reg_wr, reg_rd
   );
endinterface

// File: rtl/uart_bridge_timeout.sv
// Bus-wait watchdog: counts unacknowledged BUS_WAIT cycles.
// expired flags the wait cycle whose increment makes the count reach TIMEOUT_CYC.
module uart_bridge_timeout #(
   parameter logic [15:0] TIMEOUT_CYC = 16'd1000
) (
   input  logic clk_main,
   input  logic rst_main,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   logic [15:0] cnt;

   always_ff @(posedge clk_main or posedge rst_main) begin
      if (rst_main)    cnt <= '0;
      else if (clear)  cnt <= '0;
      else if (enable) cnt <= cnt + 16'd1;
   end

   // 17-bit compare so a full-range TIMEOUT_CYC cannot wrap
   assign expired = enable && (({1'b0, cnt} + 17'd1) >= {1'b0, TIMEOUT_CYC});

endmodule

// File: rtl/uart_cmd_bridge.sv
// UART byte-stream to register-bus bridge: parses write/read frames, issues one
// bus access, returns one response byte. UART_BRIDGE_CKSUM_EN adds an XOR trailer.
module uart_cmd_bridge
   import uart_bridge_pkg::*;
#(
   parameter logic [15:0] TIMEOUT_CYC = 16'd1000,
   parameter logic [7:0]  RESP_ACK    = 8'h4B,
   parameter logic [7:0]  RESP_ERR    = 8'h45
) (
   input  logic                 clk_main,
   input  logic                 rst_main,
   uart_cmd_bridge_if.master    bus,
   output logic                 busy,
   output logic [7:0]           err_count
);

   state_t     state;
   logic       is_wr;
   logic       resp_err;
   logic [7:0] resp;
   logic       pop;
   logic       push;
   logic       tmo_clear;
   logic       tmo_en;
   logic       tmo_expired;

   // Pop is combinational so the byte is taken in the same cycle rf_empty drops
   assign pop        = !rst_main && is_rx_state(state) && !bus.rf_empty;
   assign push       = (state == SEND_RESP) && !bus.tf_full;
   assign bus.rd_stb = pop;
   assign bus.wr_stb = push;
   assign bus.wr_in  = resp;
   assign busy       = (state != IDLE);

   assign tmo_clear  = (state == BUS_REQ);
   assign tmo_en     = (state == BUS_WAIT) && !bus.reg_ack;

   uart_bridge_timeout #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_timeout (
      .clk_main (clk_main),
      .rst_main (rst_main),
      .clear    (tmo_clear),
      .enable   (tmo_en),
      .expired  (tmo_expired)
   );

`ifdef UART_BRIDGE_CKSUM_EN
   logic [7:0] cksum;

   // Running XOR; the command byte in IDLE restarts it
   always_ff @(posedge clk_main or posedge rst_main) begin
      if (rst_main)
         cksum <= '0;
      else if (pop)
         cksum <= (state == IDLE) ? bus.rd_out : (cksum ^ bus.rd_out);
   end
`endif

   always_ff @(posedge clk_main or posedge rst_main) begin
      if (rst_main) begin
         state         <= IDLE;
         is_wr         <= 1'b0;
         resp_err      <= 1'b0;
         resp          <= '0;
         bus.reg_addr  <= '0;
         bus.reg_wdata <= '0;
         bus.reg_wr    <= 1'b0;
         bus.reg_rd    <= 1'b0;
         err_count     <= '0;
      end else begin
         bus.reg_wr <= 1'b0;
         bus.reg_rd <= 1'b0;
         case (state)
            IDLE: begin
               if (pop) begin
                  if (bus.rd_out == CMD_WR || bus.rd_out == CMD_RD) begin
                     is_wr <= (bus.rd_out == CMD_WR);
                     state <= GET_ADDR;
                  end else begin
                     resp     <= RESP_ERR;
                     resp_err <= 1'b1;
                     state    <= SEND_RESP;
                  end
               end
            end
            GET_ADDR: begin
               if (pop) begin
                  bus.reg_addr <= bus.rd_out;
                  if (is_wr) begin
                     state <= GET_DATA;
                  end else begin
`ifdef UART_BRIDGE_CKSUM_EN
                     state <= GET_CKSUM;
`else
                     state      <= BUS_REQ;
                     bus.reg_rd <= 1'b1;
`endif
                  end
               end
            end
            GET_DATA: begin
               if (pop) begin
                  bus.reg_wdata <= bus.rd_out;
`ifdef UART_BRIDGE_CKSUM_EN
                  state <= GET_CKSUM;
`else
                  state      <= BUS_REQ;
                  bus.reg_wr <= 1'b1;
`endif
               end
            end
`ifdef UART_BRIDGE_CKSUM_EN
            GET_CKSUM: begin
               if (pop) begin
                  if (bus.rd_out == cksum) begin
                     state      <= BUS_REQ;
                     bus.reg_wr <= is_wr;
                     bus.reg_rd <= !is_wr;
                  end else begin
                     resp     <= RESP_ERR;
                     resp_err <= 1'b1;
                     state    <= SEND_RESP;
                  end
               end
            end
`endif
            BUS_REQ: state <= BUS_WAIT;
            BUS_WAIT: begin
               // Ack wins over a timeout landing in the same cycle
               if (bus.reg_ack) begin
                  resp     <= is_wr ? RESP_ACK : bus.reg_rdata;
                  resp_err <= 1'b0;
                  state    <= SEND_RESP;
               end else if (tmo_expired) begin
                  resp     <= RESP_ERR;
                  resp_err <= 1'b1;
                  state    <= SEND_RESP;
               end
            end
            SEND_RESP: begin
               if (push) begin
                  state <= IDLE;
                  if (resp_err && err_count != 8'hFF)
                     err_count <= err_count + 8'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_cmd_bridge.sv
// Self-checking bench for uart_cmd_bridge: directed vector table, reset/stray-ack
// sequences, and a randomized frame stream against a frame-level reference model.
module tb_uart_cmd_bridge;
   import uart_bridge_pkg::*;

   localparam int TMO = 8;

   logic       clk = 1'b0;
   logic       rst;
   logic       busy;
   logic [7:0] err_count;

   uart_cmd_bridge_if bus();

   uart_cmd_bridge #(
      .TIMEOUT_CYC (16'd8),
      .RESP_ACK    (8'h4B),
      .RESP_ERR    (8'h45)
   ) dut (
      .clk_main  (clk),
      .rst_main  (rst),
      .bus       (bus.master),
      .busy      (busy),
      .err_count (err_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       wr;
      logic [7:0] addr;
      logic [7:0] wdata;
      int         c;
   } acc_t;

   typedef struct {
      logic [31:0] b;
      int          n;
      logic        raw;
      int          dly;
      logic [7:0]  rdata;
      int          hold;
      logic [7:0]  exp_tx;
      int          exp_acc;
      logic        exp_wr;
      logic [7:0]  exp_addr;
      logic [7:0]  exp_wdata;
      int          exp_err;
   } vec_t;

   int         npass = 0;
   int         ntot  = 0;
   int         cyc   = 0;
   int         err_exp = 0;
   logic [7:0] rx_q[$];
   logic [7:0] tx_q[$];
   int         tx_cyc[$];
   acc_t       acc_q[$];
   int         dly_q[$];
   logic [7:0] rdat_q[$];
   int         ack_at = -1;
   logic [7:0] ack_data = 8'h00;
   logic       rand_tf = 1'b0;
   logic       rand_hold = 1'b0;
   logic       stray_ack = 1'b0;
   int         cur_hold = 0;
   int         tf_release = 0;
   int         last_pop = -1;
   vec_t       vecs[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      ntot++;
      if (act === exp) npass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
   endtask

   function automatic logic [7:0] fxor(input logic [31:0] b, input int n);
      logic [7:0] x = 8'h00;
      for (int i = 0; i < n; i++) x ^= b[31-8*i -: 8];
      return x;
   endfunction

   function automatic vec_t mk(input logic [31:0] b, input int n, input logic raw,
                               input int dly, input logic [7:0] rdata, input int hold,
                               input logic [7:0] tx, input int acc, input logic wr,
                               input logic [7:0] addr, input logic [7:0] wdata, input int err);
      vec_t v;
      v.b = b; v.n = n; v.raw = raw; v.dly = dly; v.rdata = rdata; v.hold = hold;
      v.exp_tx = tx; v.exp_acc = acc; v.exp_wr = wr; v.exp_addr = addr;
      v.exp_wdata = wdata; v.exp_err = err;
      return v;
   endfunction

   task automatic push_frame(input logic [31:0] b, input int n, input logic raw);
      for (int i = 0; i < n; i++) rx_q.push_back(b[31-8*i -: 8]);
      if (!raw) begin
`ifdef UART_BRIDGE_CKSUM_EN
         rx_q.push_back(fxor(b, n));
`endif
      end
   endtask

   task automatic drive_inputs();
      bus.rf_empty  = (rx_q.size() == 0) || (rand_hold && $urandom_range(0, 3) == 0);
      bus.rd_out    = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
      bus.tf_full   = (cyc < tf_release) || (rand_tf && $urandom_range(0, 2) == 0);
      bus.reg_ack   = (ack_at == cyc) || stray_ack;
      bus.reg_rdata = (ack_at == cyc) ? ack_data : 8'($urandom);
   endtask

   // One clock: observe DUT mid-cycle, then update the environment after the edge
   task automatic step();
      logic pop;
      int   d;
      @(negedge clk);
      pop = bus.rd_stb;
      if (bus.wr_stb) begin
         chk("push_while_full", {31'd0, bus.tf_full}, 32'd0);
         tx_q.push_back(bus.wr_in);
         tx_cyc.push_back(cyc);
      end
      if (bus.reg_wr || bus.reg_rd) begin
         d = (dly_q.size() != 0) ? dly_q.pop_front() : 0;
         acc_q.push_back('{bus.reg_wr, bus.reg_addr, bus.reg_wdata, cyc});
         chk("strobe_exclusive", {31'd0, bus.reg_wr & bus.reg_rd}, 32'd0);
         ack_at   = (d > 0) ? cyc + d : -1;
         ack_data = (rdat_q.size() != 0) ? rdat_q.pop_front() : 8'($urandom);
         if (cur_hold > 0)
            tf_release = cyc + ((d >= 1 && d <= TMO) ? d : TMO) + 1 + cur_hold;
      end
      if (bus.reg_ack && ack_at == cyc && acc_q.size() != 0)
         chk("addr_stable", {24'd0, bus.reg_addr}, {24'd0, acc_q[acc_q.size()-1].addr});
      @(posedge clk);
      #1;
      cyc++;
      if (pop) begin
         last_pop = cyc - 1;
         void'(rx_q.pop_front());
      end
      drive_inputs();
   endtask

   task automatic clear_logs();
      tx_q.delete(); tx_cyc.delete(); acc_q.delete();
   endtask

   task automatic do_reset_now();
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_busy", {31'd0, busy}, 32'd0);
      chk("async_rst_rd_stb", {31'd0, bus.rd_stb}, 32'd0);
      rx_q.delete(); dly_q.delete(); rdat_q.delete();
      ack_at = -1;
      err_exp = 0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      vec_t       v;
      int         n;
      int         lat;
      int         anchor;
      logic [7:0] exp_tx[$];
      acc_t       exp_acc[$];

      // ---------------- reset state ----------------
      rst = 1'b1;
      bus.rf_empty = 1'b0; bus.rd_out = 8'h57; bus.tf_full = 1'b0;
      bus.reg_ack = 1'b1; bus.reg_rdata = 8'h00;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_rd_stb",    {31'd0, bus.rd_stb}, 32'd0);
      chk("rst_wr_stb",    {31'd0, bus.wr_stb}, 32'd0);
      chk("rst_reg_wr",    {31'd0, bus.reg_wr}, 32'd0);
      chk("rst_reg_rd",    {31'd0, bus.reg_rd}, 32'd0);
      chk("rst_busy",      {31'd0, busy}, 32'd0);
      chk("rst_wr_in",     {24'd0, bus.wr_in}, 32'd0);
      chk("rst_reg_addr",  {24'd0, bus.reg_addr}, 32'd0);
      chk("rst_reg_wdata", {24'd0, bus.reg_wdata}, 32'd0);
      chk("rst_err_count", {24'd0, err_count}, 32'd0);
      bus.reg_ack = 1'b0; bus.rf_empty = 1'b1;
      rst = 1'b0;
      drive_inputs();

      // ---------------- directed vector table ----------------
      vecs.push_back(mk(32'h5710A500, 3, 0, 3, 8'h00, 0,  8'h4B, 1, 1, 8'h10, 8'hA5, 0));
      vecs.push_back(mk(32'h52200000, 2, 0, 2, 8'h3C, 0,  8'h3C, 1, 0, 8'h20, 8'h00, 0));
      vecs.push_back(mk(32'h99000000, 1, 1, 0, 8'h00, 0,  8'h45, 0, 0, 8'h00, 8'h00, 1));
      vecs.push_back(mk(32'h52330000, 2, 0, 0, 8'h00, 0,  8'h45, 1, 0, 8'h33, 8'h00, 1));
      vecs.push_back(mk(32'h57441200, 3, 0, 3, 8'h00, 20, 8'h4B, 1, 1, 8'h44, 8'h12, 0));
      vecs.push_back(mk(32'h577F0000, 3, 0, 0, 8'h00, 0,  8'h45, 1, 1, 8'h7F, 8'h00, 1));
      vecs.push_back(mk(32'h52810000, 2, 0, 8, 8'h5A, 0,  8'h5A, 1, 0, 8'h81, 8'h00, 0));
      vecs.push_back(mk(32'h52C30000, 2, 0, 1, 8'h45, 0,  8'h45, 1, 0, 8'hC3, 8'h00, 0));
      vecs.push_back(mk(32'h00000000, 1, 1, 0, 8'h00, 0,  8'h45, 0, 0, 8'h00, 8'h00, 1));
`ifdef UART_BRIDGE_CKSUM_EN
      vecs.push_back(mk(32'h57010254, 4, 1, 2, 8'h00, 0,  8'h4B, 1, 1, 8'h01, 8'h02, 0));
      vecs.push_back(mk(32'h57010200, 4, 1, 0, 8'h00, 0,  8'h45, 0, 0, 8'h00, 8'h00, 1));
`endif

      foreach (vecs[k]) begin
         v = vecs[k];
         clear_logs();
         if (v.exp_acc != 0) begin
            dly_q.push_back(v.dly);
            rdat_q.push_back(v.rdata);
         end
         cur_hold   = v.hold;
         tf_release = (v.hold > 0) ? 32'h7fffffff : 0;
         push_frame(v.b, v.n, v.raw);
         n = 0;
         while (tx_q.size() == 0 && n < 400) begin step(); n++; end
         repeat (12) step();
         chk($sformatf("v%0d_tx_count", k), tx_q.size(), 1);
         if (tx_q.size() != 0) begin
            chk($sformatf("v%0d_tx_byte", k), {24'd0, tx_q[0]}, {24'd0, v.exp_tx});
            if (v.exp_acc != 0) begin
               anchor = (acc_q.size() != 0) ? acc_q[0].c : -1000;
               lat = ((v.dly >= 1 && v.dly <= TMO) ? v.dly : TMO) + 1 + v.hold;
            end else begin
               anchor = last_pop;
               lat = 1 + v.hold;
            end
            chk($sformatf("v%0d_latency", k), tx_cyc[0] - anchor, lat);
         end
         chk($sformatf("v%0d_acc_count", k), acc_q.size(), v.exp_acc);
         if (acc_q.size() != 0 && v.exp_acc != 0) begin
            chk($sformatf("v%0d_acc_wr", k), {31'd0, acc_q[0].wr}, {31'd0, v.exp_wr});
            chk($sformatf("v%0d_acc_addr", k), {24'd0, acc_q[0].addr}, {24'd0, v.exp_addr});
            if (v.exp_wr)
               chk($sformatf("v%0d_acc_wdata", k), {24'd0, acc_q[0].wdata}, {24'd0, v.exp_wdata});
         end
         err_exp += v.exp_err;
         chk($sformatf("v%0d_err_count", k), {24'd0, err_count}, err_exp);
         chk($sformatf("v%0d_idle", k), {31'd0, busy}, 32'd0);
         cur_hold = 0;
         tf_release = 0;
      end

      // ---------------- stray ack while idle is ignored ----------------
      clear_logs();
      stray_ack = 1'b1;
      repeat (6) step();
      stray_ack = 1'b0;
      repeat (4) step();
      chk("stray_ack_no_tx", tx_q.size(), 0);
      chk("stray_ack_idle", {31'd0, busy}, 32'd0);

      // ---------------- reset mid-frame ----------------
      clear_logs();
      rx_q.push_back(8'h57); rx_q.push_back(8'h10);
      n = 0;
      while (rx_q.size() != 0 && n < 50) begin step(); n++; end
      step();
      chk("midframe_busy", {31'd0, busy}, 32'd1);
      do_reset_now();
      chk("midframe_err_cleared", {24'd0, err_count}, 32'd0);
      drive_inputs();
      repeat (20) step();
      chk("midframe_no_tx", tx_q.size(), 0);

      // ---------------- reset mid-access ----------------
      clear_logs();
      dly_q.push_back(0);
      push_frame(32'h52550000, 2, 0);
      n = 0;
      while (acc_q.size() == 0 && n < 50) begin step(); n++; end
      chk("midaccess_strobe", acc_q.size(), 1);
      repeat (3) step();
      do_reset_now();
      drive_inputs();
      repeat (20) step();
      chk("midaccess_no_tx", tx_q.size(), 0);
      chk("midaccess_idle", {31'd0, busy}, 32'd0);

      // ---------------- randomized stream vs frame-level model ----------------
      clear_logs();
      for (int i = 0; i < 60; i++) begin
         int         kind;
         int         d;
         logic [7:0] a;
         logic [7:0] w;
         logic [7:0] c;
         kind = $urandom_range(0, 4);
         a = 8'($urandom); w = 8'($urandom);
         d = $urandom_range(0, 10);
`ifndef UART_BRIDGE_CKSUM_EN
         if (kind == 4) kind = 3;
`endif
         case (kind)
            0, 1: begin
               push_frame({8'h57, a, w, 8'h00}, 3, 0);
               dly_q.push_back(d); rdat_q.push_back(8'($urandom));
               exp_acc.push_back('{1'b1, a, w, 0});
               if (d >= 1 && d <= TMO) exp_tx.push_back(8'h4B);
               else begin exp_tx.push_back(8'h45); err_exp++; end
            end
            2: begin
               push_frame({8'h52, a, 16'h0000}, 2, 0);
               dly_q.push_back(d); rdat_q.push_back(w);
               exp_acc.push_back('{1'b0, a, 8'h00, 0});
               if (d >= 1 && d <= TMO) exp_tx.push_back(w);
               else begin exp_tx.push_back(8'h45); err_exp++; end
            end
            3: begin
               c = 8'($urandom);
               if (c == 8'h57 || c == 8'h52) c = 8'h00;
               rx_q.push_back(c);
               exp_tx.push_back(8'h45); err_exp++;
            end
            default: begin
               push_frame({8'h57, a, w, 8'h00}, 3, 1);
               rx_q.push_back(fxor({8'h57, a, w, 8'h00}, 3) ^ 8'($urandom_range(1, 255)));
               exp_tx.push_back(8'h45); err_exp++;
            end
         endcase
      end
      rand_tf = 1'b1; rand_hold = 1'b1;
      n = 0;
      while (tx_q.size() < exp_tx.size() && n < 30000) begin step(); n++; end
      rand_tf = 1'b0; rand_hold = 1'b0;
      repeat (20) step();
      chk("rand_tx_count", tx_q.size(), exp_tx.size());
      chk("rand_acc_count", acc_q.size(), exp_acc.size());
      for (int i = 0; i < exp_tx.size() && i < tx_q.size(); i++)
         chk($sformatf("rand_tx%0d", i), {24'd0, tx_q[i]}, {24'd0, exp_tx[i]});
      for (int i = 0; i < exp_acc.size() && i < acc_q.size(); i++) begin
         chk($sformatf("rand_acc%0d_wr", i), {31'd0, acc_q[i].wr}, {31'd0, exp_acc[i].wr});
         chk($sformatf("rand_acc%0d_addr", i), {24'd0, acc_q[i].addr}, {24'd0, exp_acc[i].addr});
         if (exp_acc[i].wr)
            chk($sformatf("rand_acc%0d_wdata", i), {24'd0, acc_q[i].wdata}, {24'd0, exp_acc[i].wdata});
      end
      chk("rand_err_count", {24'd0, err_count}, (err_exp > 255) ? 255 : err_exp);

      // ---------------- err_count saturation ----------------
      clear_logs();
      for (int i = 0; i < 260; i++) rx_q.push_back(8'h00);
      n = 0;
      while (tx_q.size() < 260 && n < 5000) begin step(); n++; end
      repeat (5) step();
      chk("sat_tx_count", tx_q.size(), 260);
      chk("sat_err_count", {24'd0, err_count}, 32'hFF);

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule
